pc_sequencer: RTL and testbench

//   Parametrised program-counter sequencer for the fetch stage: holds the current fetch address, advances by one

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/pc_ras.sv | 66 ++++++
 rtl/pc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared types and helpers for the program-counter sequencer.
//   - state_t : sequencer life-cycle (boot bubble, running, trap bubble)
//   - src_t   : which source wins the next-pc selection in a running cycle
//   - align_mask() : low-bit mask that must be zero for an instruction-aligned
//                    address, given the instruction size in bytes
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_RET,
        SRC_TRAP,
        SRC_HOLD
    } src_t;

    // INSN_BYTES is a power of two, so the alignment mask is simply bytes-1.
    function automatic logic [63:0] align_mask(input int unsigned insn_bytes);
        return 64'(insn_bytes) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Bundle between decode/execute (master) and the pc sequencer (slave).
//   master drives : stall, branch_taken, branch_target, jump, jump_target,
//                   trap, call, ret
//   slave drives  : pc, pc_valid, misalign_err, ras_err
//   AW : address width in bits
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int unsigned AW = 32
) ();

    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          trap;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          misalign_err;
    logic          ras_err;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               trap, call, ret,
        input  pc, pc_valid, misalign_err, ras_err
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               trap, call, ret,
        output pc, pc_valid, misalign_err, ras_err
    );

endinterface

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
//   Circular return-address stack. A push when full overwrites the oldest
//   entry. push and pop in the same cycle replace the top entry in place.
//   Ports:
//     clk, clr    : clock, synchronous active-high clear (empties the stack)
//     push, pop   : stack operations (caller only pops when not empty)
//     push_data   : address to push
//     top         : current top-of-stack value
//     empty, full : occupancy flags
// ---------------------------------------------------------------------------
module pc_ras #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;
    logic [CW-1:0] count;

    // ptr names the next free slot; wrap explicitly so DEPTH need not be 2^n.
    assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);
    assign top     = mem[ptr_dec];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    // Pointer and occupancy; count saturates at DEPTH because a full push
    // just recycles the oldest slot.
    always_ff @(posedge clk) begin
        if (clr) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !pop) begin
            ptr <= ptr_inc;
            if (!full)
                count <= count + CW'(1);
        end else if (pop && !push) begin
            ptr   <= ptr_dec;
            count <= count - CW'(1);
        end
    end

    // Storage; on pop+push the new address lands where the popped one was.
    always_ff @(posedge clk) begin
        if (push && !pop)
            mem[ptr] <= push_data;
        else if (push && pop)
            mem[ptr_dec] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Fetch-stage program counter. Advances one instruction per cycle and
//   redirects with priority trap > stall(hold) > ret > jump > branch > seq.
//   Misaligned jump/branch targets divert to TRAP_VEC with a one-cycle
//   misalign_err pulse. Boot and trap each cost one pc_valid=0 bubble.
//   Ports:
//     clk : rising-edge clock
//     clr : synchronous active-high reset, overrides all other inputs
//     bus : pc_sequencer_if.slave (redirect controls in, pc/status out)
//   Configuration macro PC_RAS_EN: adds a RAS_DEPTH-entry return-address
//   stack driven by call/ret; without it call/ret are ignored and ras_err=0.
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned   AW         = 32,
    parameter int unsigned   INSN_BYTES = 4,
    parameter logic [AW-1:0] RESET_VEC  = '0,
    parameter logic [AW-1:0] TRAP_VEC   = AW'('h80),
    parameter int unsigned   RAS_DEPTH  = 4
) (
    input logic           clk,
    input logic           clr,
    pc_sequencer_if.slave bus
);

    localparam logic [AW-1:0] ALIGN_MASK = AW'(align_mask(INSN_BYTES));

    state_t        state;
    state_t        state_next;
    src_t          src;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] seq_pc;
    logic          misalign_q;
    logic          misalign_next;
    logic          ras_err_q;
    logic          ras_err_next;
    logic          jmp_mis;
    logic          br_mis;
    logic          call_req;
    logic          ret_req;
    logic          push;
    logic          pop;
    logic          ras_empty;
    logic [AW-1:0] ras_top;

    // Sequential address wraps naturally modulo 2^AW.
    assign seq_pc  = pc_q + AW'(INSN_BYTES);
    assign jmp_mis = |(bus.jump_target & ALIGN_MASK);
    assign br_mis  = |(bus.branch_target & ALIGN_MASK);

`ifdef PC_RAS_EN
    logic ras_full_unused;

    assign call_req = bus.call;
    assign ret_req  = bus.ret;

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_unused)
    );
`else
    logic unused_ras;

    assign call_req   = 1'b0;
    assign ret_req    = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign unused_ras = ^{push, pop, bus.call, bus.ret};
`endif

    // State, pc and the registered error pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            ras_err_q  <= 1'b0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            misalign_q <= misalign_next;
            ras_err_q  <= ras_err_next;
        end
    end

    // Next-state / next-pc selection. Bubble states only honour trap; a
    // running cycle picks one winning source and only that source's target
    // is alignment-checked. A call pushes alongside whichever source wins,
    // unless the cycle is held or trapped.
    always_comb begin
        state_next    = state;
        pc_next       = pc_q;
        misalign_next = 1'b0;
        ras_err_next  = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        src           = SRC_HOLD;
        case (state)
            S_BOOT, S_TRAP: begin
                if (bus.trap) begin
                    src        = SRC_TRAP;
                    state_next = S_TRAP;
                    pc_next    = TRAP_VEC;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.trap)              src = SRC_TRAP;
                else if (bus.stall)        src = SRC_HOLD;
                else if (ret_req)          src = SRC_RET;
                else if (bus.jump)         src = SRC_JMP;
                else if (bus.branch_taken) src = SRC_BR;
                else                       src = SRC_SEQ;

                push = call_req && !bus.trap && !bus.stall;

                case (src)
                    SRC_TRAP: begin
                        pc_next    = TRAP_VEC;
                        state_next = S_TRAP;
                    end
                    SRC_RET: begin
                        if (ras_empty) begin
                            ras_err_next = 1'b1;
                            pc_next      = seq_pc;
                        end else begin
                            pop     = 1'b1;
                            pc_next = ras_top;
                        end
                    end
                    SRC_JMP: begin
                        if (jmp_mis) begin
                            pc_next       = TRAP_VEC;
                            misalign_next = 1'b1;
                            state_next    = S_TRAP;
                        end else begin
                            pc_next = bus.jump_target;
                        end
                    end
                    SRC_BR: begin
                        if (br_mis) begin
                            pc_next       = TRAP_VEC;
                            misalign_next = 1'b1;
                            state_next    = S_TRAP;
                        end else begin
                            pc_next = bus.branch_target;
                        end
                    end
                    SRC_SEQ:  pc_next = seq_pc;
                    default:  pc_next = pc_q;
                endcase
            end
            default: state_next = S_BOOT;
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.pc_valid     = (state == S_RUN);
    assign bus.misalign_err = misalign_q;
    assign bus.ras_err      = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   behavioural model (pc value, a running/bubble flag and a queue as stack).
//   Honours PC_RAS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int unsigned AW         = 32;
    localparam int unsigned INSN_BYTES = 4;
    localparam logic [31:0] RESET_VEC  = 32'h0;
    localparam logic [31:0] TRAP_VEC   = 32'h80;
    localparam int unsigned RAS_DEPTH  = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    pc_sequencer_if #(.AW(AW)) bus ();

    pc_sequencer #(
        .AW         (AW),
        .INSN_BYTES (INSN_BYTES),
        .RESET_VEC  (RESET_VEC),
        .TRAP_VEC   (TRAP_VEC),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state: running means pc_valid; stack is a queue
    // whose back is the most recent return address.
    logic [31:0] m_pc;
    bit          m_running = 1'b0;
    bit          m_mis     = 1'b0;
    bit          m_rerr    = 1'b0;
    bit          m_ready   = 1'b0;
    logic [31:0] m_stack[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit c, input bit st, input bit br,
                                 input logic [31:0] bt, input bit j,
                                 input logic [31:0] jt, input bit tr,
                                 input bit ca, input bit re);
        clr               = c;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump          = j;
        bus.jump_target   = jt;
        bus.trap          = tr;
        bus.call          = ca;
        bus.ret           = re;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkPc(input string name, input logic [31:0] pc,
                           input bit valid);
        checkOutput({name, "_pc"}, bus.pc, pc);
        checkOutput({name, "_valid"}, 32'(bus.pc_valid), 32'(valid));
    endtask

    // Reference model: advanced once per rising edge from the inputs
    // that were held across that edge.
    always @(posedge clk) begin
        logic [31:0] seq;
        logic [31:0] nxt;
        bit          redir;
        m_mis  = 1'b0;
        m_rerr = 1'b0;
        if (clr) begin
            m_pc      = RESET_VEC;
            m_running = 1'b0;
            m_stack.delete();
            m_ready   = 1'b1;
        end else if (!m_running) begin
            if (bus.trap) m_pc = TRAP_VEC;
            else          m_running = 1'b1;
        end else if (bus.trap) begin
            m_pc      = TRAP_VEC;
            m_running = 1'b0;
        end else if (!bus.stall) begin
            seq   = m_pc + INSN_BYTES;
            nxt   = seq;
            redir = 1'b0;
            if (RAS_ON && bus.ret && m_stack.size() > 0) begin
                nxt = m_stack.pop_back();
            end else if (RAS_ON && bus.ret) begin
                m_rerr = 1'b1;
            end else if (bus.jump) begin
                nxt   = bus.jump_target;
                redir = 1'b1;
            end else if (bus.branch_taken) begin
                nxt   = bus.branch_target;
                redir = 1'b1;
            end
            if (redir && (nxt % INSN_BYTES) != 0) begin
                m_mis     = 1'b1;
                nxt       = TRAP_VEC;
                m_running = 1'b0;
            end
            if (RAS_ON && bus.call) begin
                if (m_stack.size() == RAS_DEPTH) void'(m_stack.pop_front());
                m_stack.push_back(seq);
            end
            m_pc = nxt;
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_ready) begin
            checkOutput("model_pc", bus.pc, m_pc);
            checkOutput("model_valid", 32'(bus.pc_valid), 32'(m_running));
            checkOutput("model_misalign", 32'(bus.misalign_err), 32'(m_mis));
            checkOutput("model_ras_err", 32'(bus.ras_err), 32'(m_rerr));
        end
    end

    initial begin
        logic [31:0] bt;
        logic [31:0] jt;

        // Reset held two cycles: boot bubble, then 0, 4, 8.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        step();
        checkPc("t1_reset", 32'h0, 0);
        checkOutput("t1_reset_mis", 32'(bus.misalign_err), 32'h0);
        checkOutput("t1_reset_rerr", 32'(bus.ras_err), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t1_run0", 32'h0, 1);
        step(); checkPc("t1_run4", 32'h4, 1);
        step(); checkPc("t1_run8", 32'h8, 1);

        // Jump beats branch; stall holds.
        applyStimulus(0, 0, 1, 32'h100, 1, 32'h200, 0, 0, 0);
        step(); checkPc("t2_jump", 32'h200, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t2_stall1", 32'h200, 1);
        step(); checkPc("t2_stall2", 32'h200, 1);

        // Misaligned jump diverts to the trap vector with a bubble.
        applyStimulus(0, 0, 0, 0, 1, 32'h102, 0, 0, 0);
        step(); checkPc("t3_mis", 32'h80, 0);
        checkOutput("t3_mis_pulse", 32'(bus.misalign_err), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t3_trap80", 32'h80, 1);
        checkOutput("t3_mis_clear", 32'(bus.misalign_err), 32'h0);
        step(); checkPc("t3_trap84", 32'h84, 1);

        // Top-of-space wrap, then trap overriding stall.
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(); checkPc("t4_top", 32'hFFFF_FFFC, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t4_wrap", 32'h0, 1);
        checkOutput("t4_wrap_mis", 32'(bus.misalign_err), 32'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0);
        step(); checkPc("t4_trapstall", 32'h80, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t4_after", 32'h80, 1);

`ifdef PC_RAS_EN
        // call+jump, ret, then overflow and underflow of the stack.
        applyStimulus(0, 0, 0, 0, 1, 32'h10, 0, 0, 0);
        step(); checkPc("t5_at10", 32'h10, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 1, 0);
        step(); checkPc("t5_call", 32'h40, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(); checkPc("t5_ret", 32'h14, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 5; k++) step();
        checkPc("t5_calls", 32'h28, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(); checkPc("t5_pop1", 32'h28, 1);
        step(); checkPc("t5_pop2", 32'h24, 1);
        step(); checkPc("t5_pop3", 32'h20, 1);
        step(); checkPc("t5_pop4", 32'h1c, 1);
        checkOutput("t5_pop4_rerr", 32'(bus.ras_err), 32'h0);
        step(); checkPc("t5_empty", 32'h20, 1);
        checkOutput("t5_empty_rerr", 32'(bus.ras_err), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); checkOutput("t5_rerr_pulse", 32'(bus.ras_err), 32'h0);
`endif

        // Reset wins during a trap bubble and during a stall.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); checkPc("t6_trap", 32'h80, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(); checkPc("t6_clr_trap", 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t6_run", 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, RAS_ON, 0);
        step(); checkPc("t6_call", 32'h4, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t6_clr_stall", 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); checkPc("t6_run2", 32'h0, 1);
`ifdef PC_RAS_EN
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(); checkPc("t6_ret_empty", 32'h4, 1);
        checkOutput("t6_ras_cleared", 32'(bus.ras_err), 32'h1);
`endif

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            bt = $urandom & 32'hFFFF_FFFC;
            jt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) bt = bt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) jt = jt | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) jt = 32'hFFFF_FFF0 | (jt & 32'hF);
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0, bt,
                          $urandom_range(0, 7) == 0, jt,
                          $urandom_range(0, 19) == 0,
                          RAS_ON && ($urandom_range(0, 4) == 0),
                          RAS_ON && ($urandom_range(0, 4) == 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
